// File: rtl/win3_stream_gen_if.sv
// Stream bundle between a pixel source, win3_stream_gen and the sorter.
//   s_valid/s_ready/s_data/s_last : input pixel stream, s_last marks end of line
//   m_valid/m_ready               : output window handshake
//   m_in1/m_in2/m_in3             : left/centre/right taps for the sorter
//   m_first/m_last                : window is first/last of its line
// slave  : the window generator
// master : the pixel source / window consumer side
interface win3_stream_gen_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_in1;
  logic [DATA_W-1:0] m_in2;
  logic [DATA_W-1:0] m_in3;
  logic              m_first;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_in1, m_in2, m_in3, m_first, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_in1, m_in2, m_in3, m_first, m_last
  );
endinterface

// File: rtl/win3_stream_gen.sv
// 3-tap window generator feeding a min/mid/max sorter (1-D median filter).
// One window (left, centre, right) is produced per input pixel; the line
// ends replicate the edge pixel.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset, discards any partial line
//   bus : win3_stream_gen_if slave (input pixel stream, output windows)
module win3_stream_gen #(
  parameter int DATA_W = 16
) (
  input  logic clk,
  input  logic rst,
  win3_stream_gen_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;   // left tap candidate
  logic [DATA_W-1:0] b_q, b_d;   // centre tap candidate
  logic              fp_q, fp_d; // next window is first of its line

  logic              mv_q;
  logic [DATA_W-1:0] in1_q, in2_q, in3_q;
  logic              first_q, last_q;

  logic              slot_free;
  logic              accept;
  logic              fire;
  logic [DATA_W-1:0] f1, f2, f3;
  logic              ffirst, flast;

  assign slot_free   = !mv_q || bus.m_ready;
  assign bus.s_ready = slot_free && (state_q != FLUSH);
  assign accept      = bus.s_valid && bus.s_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fp_d    = fp_q;
    fire    = 1'b0;
    f1      = '0;
    f2      = '0;
    f3      = '0;
    ffirst  = 1'b0;
    flast   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          if (bus.s_last) begin
            // single-pixel line: all three taps are the same pixel
            fire   = 1'b1;
            f1     = bus.s_data;
            f2     = bus.s_data;
            f3     = bus.s_data;
            ffirst = 1'b1;
            flast  = 1'b1;
          end else begin
            a_d     = bus.s_data;
            b_d     = bus.s_data;
            fp_d    = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (accept) begin
          fire    = 1'b1;
          f1      = a_q;
          f2      = b_q;
          f3      = bus.s_data;
          ffirst  = fp_q;
          a_d     = b_q;
          b_d     = bus.s_data;
          fp_d    = 1'b0;
          if (bus.s_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // input is stalled here; emit the last window with right edge replicated
        if (slot_free) begin
          fire    = 1'b1;
          f1      = a_q;
          f2      = b_q;
          f3      = b_q;
          ffirst  = fp_q;
          flast   = 1'b1;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      fp_q    <= 1'b0;
      mv_q    <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      in3_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fp_q    <= fp_d;
      if (fire) begin
        mv_q    <= 1'b1;
        in1_q   <= f1;
        in2_q   <= f2;
        in3_q   <= f3;
        first_q <= ffirst;
        last_q  <= flast;
      end else if (slot_free) begin
        mv_q <= 1'b0;
      end
    end
  end

  assign bus.m_valid = mv_q;
  assign bus.m_in1   = in1_q;
  assign bus.m_in2   = in2_q;
  assign bus.m_in3   = in3_q;
  assign bus.m_first = first_q;
  assign bus.m_last  = last_q;

endmodule

// File: tb/tb_win3_stream_gen.sv
// Self-checking bench for win3_stream_gen: directed lines, backpressure,
// mid-line reset and a long randomized run against a line-level window model.
module tb_win3_stream_gen;
  localparam int W = 16;

  logic clk;
  logic rst;

  win3_stream_gen_if #(.DATA_W(W)) bus();
  win3_stream_gen #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned beats = 0;
  int unsigned exp_pushed = 0;
  int unsigned low_cnt = 0;
  int          ready_mode = 0; // 0: always ready, 1: random, 2: ready_force
  logic        ready_force = 1'b1;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] win(input logic [W-1:0] l, input logic [W-1:0] c,
                                      input logic [W-1:0] r, input logic f, input logic lst);
    return {14'b0, l, c, r, f, lst};
  endfunction

  function automatic logic [63:0] cur();
    return win(bus.m_in1, bus.m_in2, bus.m_in3, bus.m_first, bus.m_last);
  endfunction

  // Reference: window k of an N-pixel line is (p[k-1], p[k], p[k+1]) with
  // indices clamped to the line, first when k==0, last when k==N-1.
  task automatic build_line(input logic [W-1:0] px[$]);
    int n;
    n = px.size();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(win(px[(k == 0) ? 0 : k-1], px[k], px[(k == n-1) ? k : k+1],
                          k == 0, k == n-1));
      exp_pushed++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push(input logic [W-1:0] d, input logic l, input int gap);
    int waitc;
    waitc = 0;
    while (gap > 0 && $urandom_range(99) < gap) begin
      bus.s_valid = 1'b0;
      bus.s_data  = W'($urandom);
      bus.s_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    forever begin
      @(negedge clk);
      if (bus.s_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waitc++;
      if (waitc > 1000) begin
        total++; bad++;
        $error("FAIL push_timeout observed=stalled expected=accept data=%h", d);
        break;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic send_line(input logic [W-1:0] px[$], input int gap);
    for (int k = 0; k < px.size(); k++) push(px[k], k == px.size()-1, gap);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // m_ready driver, updated 2 time units after each rising edge
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ($urandom_range(99) < 80);
        default: bus.m_ready = ready_force;
      endcase
    end
  end

  // Output monitor: scoreboard every beat and check hold under backpressure
  initial begin : mon
    logic        stall;
    logic [63:0] saved;
    stall = 1'b0;
    saved = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (!bus.s_ready) low_cnt++;
        if (stall) begin
          check("hold_valid", 64'(bus.m_valid), 64'd1);
          check("hold_taps", cur(), saved);
        end
        if (bus.m_valid && bus.m_ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $error("FAIL extra_window observed=%h expected=none", cur());
          end else begin
            check("window", cur(), exp_q.pop_front());
          end
        end
        stall = bus.m_valid && !bus.m_ready;
        saved = cur();
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [W-1:0] px[$];
    int unsigned  b0, l0, n;

    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", 64'(bus.m_valid), 64'd0);
    check("rst_taps", cur(), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_sready", 64'(bus.s_ready), 64'd1);

    // line 1,2,3,4
    px = '{16'd1, 16'd2, 16'd3, 16'd4};
    build_line(px);
    b0 = beats; l0 = low_cnt;
    push(16'd1, 1'b0, 0);
    check("t1_nofire", 64'(bus.m_valid), 64'd0);
    push(16'd2, 1'b0, 0);
    check("t1_lat_valid", 64'(bus.m_valid), 64'd1);
    check("t1_lat_taps", cur(), win(16'd1, 16'd1, 16'd2, 1'b1, 1'b0));
    push(16'd3, 1'b0, 0);
    push(16'd4, 1'b1, 0);
    drain();
    check("t1_beats", 64'(beats - b0), 64'd4);
    check("t1_sready_low", 64'(low_cnt - l0), 64'd1);

    // single-pixel line
    px = '{16'd7};
    build_line(px);
    b0 = beats; l0 = low_cnt;
    push(16'd7, 1'b1, 0);
    check("t2_lat_valid", 64'(bus.m_valid), 64'd1);
    check("t2_lat_taps", cur(), win(16'd7, 16'd7, 16'd7, 1'b1, 1'b1));
    drain();
    check("t2_beats", 64'(beats - b0), 64'd1);
    check("t2_sready_low", 64'(low_cnt - l0), 64'd0);

    // two-pixel line
    px = '{16'd5, 16'd9};
    build_line(px);
    b0 = beats; l0 = low_cnt;
    send_line(px, 0);
    drain();
    check("t3_beats", 64'(beats - b0), 64'd2);
    check("t3_sready_low", 64'(low_cnt - l0), 64'd1);

    // backpressure for 3 cycles mid-line
    ready_mode = 2;
    ready_force = 1'b0;
    px = '{16'd10, 16'd20, 16'd30, 16'd40};
    build_line(px);
    b0 = beats;
    push(16'd10, 1'b0, 0);
    push(16'd20, 1'b0, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'd30;
    bus.s_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stall_sready", 64'(bus.s_ready), 64'd0);
      check("t4_stall_taps", cur(), win(16'd10, 16'd10, 16'd20, 1'b1, 1'b0));
      @(posedge clk); #1;
    end
    ready_force = 1'b1;
    push(16'd30, 1'b0, 0);
    push(16'd40, 1'b1, 0);
    drain();
    ready_mode = 0;
    check("t4_beats", 64'(beats - b0), 64'd4);

    // reset in the middle of a line
    exp_q.push_back(win(16'd1, 16'd1, 16'd2, 1'b1, 1'b0));
    exp_pushed++;
    push(16'd1, 1'b0, 0);
    push(16'd2, 1'b0, 0);
    push(16'd3, 1'b0, 0);
    rst = 1'b1;
    #1;
    check("t5_async_mvalid", 64'(bus.m_valid), 64'd0);
    check("t5_async_taps", cur(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_pre_left", 64'(exp_q.size()), 64'd0);
    px = '{16'd8, 16'd9};
    build_line(px);
    b0 = beats;
    send_line(px, 0);
    drain();
    check("t5_beats", 64'(beats - b0), 64'd2);

    // randomized lines with random source gaps and sink backpressure
    ready_mode = 1;
    for (int line = 0; line < 1000; line++) begin
      n = $urandom_range(64, 1);
      px = {};
      for (int k = 0; k < int'(n); k++) px.push_back(W'($urandom));
      build_line(px);
      send_line(px, 20);
    end
    drain();
    ready_mode = 0;
    check("beats_total", 64'(beats), 64'(exp_pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
